// File: rtl/ldpc_syndrome_encoder_if.sv
// ldpc_syndrome_encoder_if: handshake bundle between a key source / syndrome
// sink (master) and the syndrome encoder (slave).
//   start              : begin a block (master -> slave)
//   in_valid/in_bit    : serial key bit stream, in_ready back-pressure
//   out_valid/out_data : W-bit syndrome words, out_last marks the final word,
//   out_ready          : sink acceptance
//   busy/done          : block status, done pulses after the last word
interface ldpc_syndrome_encoder_if #(
  parameter int unsigned W = 16
);
  logic         start;
  logic         in_valid;
  logic         in_bit;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  start, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/ldpc_syndrome_encoder.sv
// ldpc_syndrome_encoder: accumulates the M-bit LDPC syndrome s = H*x over
// GF(2) from an N-bit key block received one bit per cycle, then streams the
// syndrome out as M/W words of W bits (word k carries s[k*W +: W]).
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, discards any partial block
//   bus  : slave side of ldpc_syndrome_encoder_if (start, key input stream,
//          syndrome output stream, busy/done status); all outputs registered
module ldpc_syndrome_encoder #(
  parameter int unsigned N    = 1024,
  parameter int unsigned M    = 256,
  parameter int unsigned DV   = 3,
  parameter int unsigned IDXW = 8,
  parameter int unsigned W    = 16,
  parameter int unsigned CNTW = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  ldpc_syndrome_encoder_if.slave    bus
);

  localparam int unsigned NWORDS = M / W;
  localparam int unsigned WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  // Column-indexed parity-check table: check index of the d-th edge of key bit j
  // (quasi-cyclic layout, stride 3 between the edges of one column).
  function automatic logic [IDXW-1:0] h_col(input logic [CNTW-1:0] j, input int unsigned d);
    return IDXW'((32'(j) + 32'(3 * d)) % M);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [M-1:0]     syn_q, syn_d;
  logic [CNTW-1:0]  col_cnt_q, col_cnt_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic             done_d;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  logic             out_last_q;
  logic             busy_q;
  logic             done_q;

  // Next-state: counters, syndrome accumulation and block sequencing
  always_comb begin
    state_d    = state_q;
    syn_d      = syn_q;
    col_cnt_d  = col_cnt_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          syn_d     = '0;
          col_cnt_d = '0;
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          // Repeated indices toggle twice and cancel, as GF(2) requires
          if (bus.in_bit) begin
            for (int unsigned d = 0; d < DV; d++) begin
              syn_d[h_col(col_cnt_q, d)] = ~syn_d[h_col(col_cnt_q, d)];
            end
          end
          if (col_cnt_q == CNTW'(N - 1)) begin
            col_cnt_d  = '0;
            word_cnt_d = '0;
            state_d    = ST_EMIT;
          end else begin
            col_cnt_d = col_cnt_q + CNTW'(1);
          end
        end
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          if (word_cnt_q == WCW'(NWORDS - 1)) begin
            word_cnt_d = '0;
            state_d    = ST_IDLE;
            done_d     = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; outputs track the next state so they line up
  // with the state they describe, with no input-to-output combinational path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      syn_q       <= '0;
      col_cnt_q   <= '0;
      word_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      syn_q       <= syn_d;
      col_cnt_q   <= col_cnt_d;
      word_cnt_q  <= word_cnt_d;
      in_ready_q  <= (state_d == ST_ACCUM);
      out_valid_q <= (state_d == ST_EMIT);
      out_data_q  <= (state_d == ST_EMIT) ? syn_d[int'(word_cnt_d) * W +: W] : '0;
      out_last_q  <= (state_d == ST_EMIT) && (word_cnt_d == WCW'(NWORDS - 1));
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ldpc_syndrome_encoder.sv
// Self-checking bench for ldpc_syndrome_encoder in the small configuration
// N=16, M=8, W=4, DV=3, h_col(j,d)=(j+3d) mod 8. Inputs change on the falling
// edge and outputs are sampled there, half a cycle from the active edge.
module tb_ldpc_syndrome_encoder;

  localparam int unsigned N = 16;
  localparam int unsigned M = 8;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ldpc_syndrome_encoder_if #(.W(W)) ifc ();

  ldpc_syndrome_encoder #(
    .N(N), .M(M), .DV(3), .IDXW(3), .W(W), .CNTW(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic [15:0] key;
    bit          toggle;
    int          stall;
    bit          start_mid;
    logic [3:0]  w0;
    logic [3:0]  w1;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Syndrome straight from the definition: every set key bit j flips the
  // three checks (j+3d) mod 8.
  function automatic logic [7:0] model(input logic [15:0] key);
    logic [7:0] s;
    s = '0;
    for (int j = 0; j < 16; j++)
      if (key[j])
        for (int d = 0; d < 3; d++)
          s[(j + 3 * d) % 8] = ~s[(j + 3 * d) % 8];
    return s;
  endfunction

  task automatic start_block();
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("in_ready_after_start", 32'(ifc.in_ready), 32'd1);
    chk("busy_after_start", 32'(ifc.busy), 32'd1);
  endtask

  // Feeds the 16 key bits; optional idle cycles between bits and a stray start.
  task automatic send_bits(input logic [15:0] key, input bit toggle, input bit start_mid);
    for (int j = 0; j < 16; j++) begin
      ifc.in_valid = 1'b1;
      ifc.in_bit   = key[j];
      if (start_mid && j == 5) ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      if (toggle && j < 15) begin
        ifc.in_valid = 1'b0;
        ifc.in_bit   = ~key[j];
        @(negedge clk);
      end
    end
    ifc.in_valid = 1'b0;
    ifc.in_bit   = 1'b0;
    chk("out_valid_no_bubble", 32'(ifc.out_valid), 32'd1);
  endtask

  // Drains both words, optionally stalling word 0; checks done afterwards.
  task automatic collect(input logic [3:0] w0, input logic [3:0] w1, input int stall,
                         input bit start_mid, input bit hold_start);
    logic [3:0] exp;
    for (int k = 0; k < 2; k++) begin
      exp = (k == 0) ? w0 : w1;
      chk("out_valid", 32'(ifc.out_valid), 32'd1);
      chk("out_data", 32'(ifc.out_data), 32'(exp));
      chk("out_last", 32'(ifc.out_last), 32'(k == 1));
      if (k == 0 && stall > 0) begin
        ifc.out_ready = 1'b0;
        for (int c = 0; c < stall; c++) begin
          if (start_mid && c == 0) ifc.start = 1'b1;
          @(negedge clk);
          ifc.start = 1'b0;
          chk("stall_valid", 32'(ifc.out_valid), 32'd1);
          chk("stall_data_held", 32'(ifc.out_data), 32'(exp));
          chk("stall_last_held", 32'(ifc.out_last), 32'd0);
        end
        ifc.out_ready = 1'b1;
      end
      if (k == 1 && hold_start) ifc.start = 1'b1;
      @(negedge clk);
    end
    chk("done_pulse", 32'(ifc.done), 32'd1);
    chk("busy_at_done", 32'(ifc.busy), 32'd0);
    chk("out_valid_at_done", 32'(ifc.out_valid), 32'd0);
    if (!hold_start) begin
      @(negedge clk);
      chk("done_one_cycle", 32'(ifc.done), 32'd0);
      chk("idle_in_ready", 32'(ifc.in_ready), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] s;
    rst           = 1'b1;
    ifc.start     = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_bit    = 1'b0;
    ifc.out_ready = 1'b1;

    tbl[0] = '{16'h0000, 1'b0, 0, 1'b0, 4'h0, 4'h0};
    tbl[1] = '{16'h0001, 1'b0, 0, 1'b0, 4'h9, 4'h4};
    tbl[2] = '{16'h0003, 1'b0, 0, 1'b0, 4'hB, 4'hD};
    tbl[3] = '{16'h0001, 1'b1, 3, 1'b0, 4'h9, 4'h4};
    tbl[4] = '{16'h0001, 1'b0, 2, 1'b1, 4'h9, 4'h4};
    for (int i = 5; i < 9; i++) begin
      tbl[i].key       = 16'($urandom);
      tbl[i].toggle    = 1'($urandom_range(0, 1));
      tbl[i].stall     = int'($urandom_range(0, 3));
      tbl[i].start_mid = 1'b0;
      s                = model(tbl[i].key);
      tbl[i].w0        = s[3:0];
      tbl[i].w1        = s[7:4];
    end

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      start_block();
      send_bits(tbl[i].key, tbl[i].toggle, tbl[i].start_mid);
      collect(tbl[i].w0, tbl[i].w1, tbl[i].stall, tbl[i].start_mid, 1'b0);
    end

    // Asynchronous reset after 7 bits of an all-ones key
    start_block();
    ifc.in_valid = 1'b1;
    ifc.in_bit   = 1'b1;
    repeat (7) @(negedge clk);
    ifc.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("async_rst_busy", 32'(ifc.busy), 32'd0);
    chk("async_rst_out_data", 32'(ifc.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_block();
    send_bits(16'h0001, 1'b0, 1'b0);
    collect(4'h9, 4'h4, 0, 1'b0, 1'b0);

    // start held high across done restarts immediately with a cleared syndrome
    start_block();
    s = model(16'hFFFF);
    send_bits(16'hFFFF, 1'b0, 1'b0);
    collect(s[3:0], s[7:4], 0, 1'b0, 1'b1);
    @(negedge clk);
    ifc.start = 1'b0;
    chk("restart_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("restart_busy", 32'(ifc.busy), 32'd1);
    chk("restart_done_low", 32'(ifc.done), 32'd0);
    send_bits(16'h0001, 1'b0, 1'b0);
    collect(4'h9, 4'h4, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldpc_syndrome_encoder.md
# ldpc_syndrome_encoder

Transmit-side (Alice) companion of the LDPC decoder used for QKD key reconciliation. Accepts one sifted-key block of N bits, serially and one bit per transfer, and accumulates the M-bit syndrome s = H·x over GF(2) using a column-indexed parity-check table. It then streams the syndrome out in W-bit words for transmission to the decoding side.

## Interface

Parameters:
- N, 1024: key block length in bits (variable nodes).
- M, 256: number of checks (syndrome bits); must be a multiple of W.
- DV, 3: column weight, the number of check indices per key bit.
- IDXW, 8: check-index width; must satisfy 2^IDXW ≥ M.
- W, 16: output word width.
- CNTW, 11: column-counter width; must satisfy 2^CNTW > N.

Parity-check table:
- Supplied by the tables include as function h_col(j, d), 0 ≤ j < N, 0 ≤ d < DV.
- Returns an IDXW-bit check index below M.

Ports:
- clk, in, 1: the block's single clock; all state changes on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: begin a block; honoured only in IDLE.
- in_valid, in, 1: in_bit is valid.
- in_bit, in, 1: key bit x[j], with j = 0 presented first.
- in_ready, out, 1: block accepts a key bit.
- out_valid, out, 1: out_data holds a syndrome word.
- out_data, out, W: syndrome word; out_data[i] = s[k·W+i] for word k.
- out_last, out, 1: current word is the last one (k = M/W−1).
- out_ready, in, 1: downstream accepts the word.
- busy, out, 1: state is not IDLE.
- done, out, 1: one-cycle pulse after the last word transfers.

## Operation

- Internal state:
  - state ∈ {IDLE, ACCUM, EMIT}
  - syn[M−1:0]
  - col_cnt[CNTW−1:0]
  - word_cnt, wide enough for M/W−1.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: clear syn to 0, set col_cnt=0, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - A transfer is the cycle where in_valid=1 and in_ready=1.
  - On a transfer with in_bit=1: syn[h_col(col_cnt,d)] is XOR-toggled for every d in 0..DV−1, all in the same cycle.
  - Duplicate indices within one column toggle once per occurrence. Two equal indices therefore cancel, which is pure GF(2) semantics.
  - On a transfer with in_bit=0: syn is unchanged.
  - Every transfer increments col_cnt.
  - The transfer at col_cnt=N−1 moves to EMIT with word_cnt=0, and col_cnt wraps to 0.
  - in_valid=0 cycles are stalls: no state change.
- EMIT:
  - out_valid=1, out_data=syn[word_cnt·W +: W], out_last=(word_cnt==M/W−1).
  - A transfer is the cycle where out_valid=1 and out_ready=1.
  - On a transfer: word_cnt increments.
  - On the transfer with out_last=1: go to IDLE and pulse done for the next cycle.
  - syn is held constant throughout EMIT.
- start outside IDLE is ignored; there is no restart mid-block.
- in_valid in IDLE or EMIT is ignored; no bit is consumed.
- Reset, asynchronous and at any time including mid-ACCUM or mid-EMIT:
  - state=IDLE, syn=0, col_cnt=0, word_cnt=0.
  - Outputs: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - The partial block is discarded.

## Timing

- in_ready, out_valid, out_data, out_last and busy are decoded from registered state and counters only. There is no combinational path from in_valid or out_ready to any output.
- Key bit accepted at edge t updates syn at edge t; throughput is 1 bit per cycle.
- Cycle after start sampled in IDLE: in_ready=1.
- Cycle after the N-th accepted bit: out_valid=1 with word 0; there are no bubble cycles.
- Output throughput is 1 word per cycle when out_ready=1.
- Under out_ready=0: out_data and out_last stay stable until the transfer.
- done is high exactly one cycle, the cycle after the last word transfer, coinciding with busy=0.
- Minimum block time: 1 start cycle + N input cycles + M/W output cycles.
- Earliest start for the next block: the cycle done is high.

## Test plan

Bench configuration: N=16, M=8, W=4, DV=3, IDXW=3, CNTW=5, h_col(j,d)=(j+3d) mod 8.

- All-zero key, out_ready=1:
  - Required: two words, 0x0 then 0x0.
  - out_last only on word 1; done one cycle later.
  - First out_valid the cycle after the 16th bit.
- Only x[0]=1: syndrome bits {0,3,6}.
  - Required: word0=0x9, word1=0x4.
- x[0]=x[1]=1: bits {0,1,3,4,6,7}.
  - Required: word0=0xB, word1=0xD.
- x[0]=1 fed with in_valid toggling 1,0,1,0…; out_ready low for 3 cycles after out_valid rises.
  - Required: still 0x9, 0x4.
  - out_data held during the stall; no word duplicated or dropped.
- rst asserted after 7 bits of an all-ones key, then a new block with only x[0]=1:
  - Required: outputs go to reset values immediately.
  - Second block yields 0x9, 0x4.
- start pulsed during ACCUM and during EMIT:
  - Required: ignored, col_cnt unaffected, output words correct.
- start held high across done:
  - Required: a new block begins and syn is cleared.
